// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline types for the hazard controller
package hazard_ctrl_pkg;
  typedef logic [4:0] reg_ind_t;
  typedef struct packed {
    logic l;
    logic w;
    logic m;
  } control_signals_t;
  typedef enum logic [2:0] {F, D, E, M, W} stage_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  localparam int NSTAGE = 5;
  function automatic logic [NSTAGE-1:0] st(stage_t s);
    return 5'(1) << s;
  endfunction
endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// md_seq: mul/div start/busy/done sequencer with latency counter
module md_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic md_start,
  output logic md_busy,
  output logic md_hold
);
  md_state_t state, state_n;
  logic [5:0] cnt, cnt_n, load;
  assign load = 6'(is_div ? DIV_LAT - 2 : MUL_LAT - 2);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    md_start = state == IDLE && start;
    md_busy = state == BUSY;
    md_hold = md_start || md_busy;
    if (md_start) begin
      cnt_n = load;
      state_n = load == 6'd0 ? DONE : BUSY;
    end else if (md_busy) begin
      cnt_n = cnt - 6'd1;
      state_n = cnt == 6'd1 ? DONE : BUSY;
    end else if (state == DONE)
      state_n = IDLE;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush scheduler for the RV32IM pipeline; HAZARD_CTRL_RV32M_EN adds mul/div sequencing
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  input  reg_ind_t         d_rs1,
  input  reg_ind_t         d_rs2,
  input  logic             d_use_rs1,
  input  logic             d_use_rs2,
  input  logic             e_valid,
  input  reg_ind_t         e_rd,
  input  control_signals_t e_cs,
  input  logic [2:0]       e_func3,
  input  logic             e_redirect,
  output logic [4:0]       stalls,
  output logic [4:0]       flushes,
  output logic             md_start,
  output logic             md_busy
);
  logic load_use, md_hold, unused_ok;
  assign load_use = e_valid && e_cs.l && e_rd != '0 && d_valid &&
                    ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));
`ifdef HAZARD_CTRL_RV32M_EN
  logic seq_busy;
  md_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_md_seq (
    .clk(clk),
    .rst(rst),
    .start(e_valid && e_cs.m && !e_redirect && !rst),
    .is_div(e_func3[2]),
    .md_start(md_start),
    .md_busy(seq_busy),
    .md_hold(md_hold)
  );
  assign md_busy = seq_busy && !rst;
  assign unused_ok = ^{e_cs.w, e_func3[1:0]};
  always_ff @(posedge clk)
    if (!rst) assert (!(e_redirect && e_cs.m));
`else
  assign md_start = 1'b0;
  assign md_busy = 1'b0;
  assign md_hold = 1'b0;
  assign unused_ok = ^{e_cs.w, e_func3};
  always_ff @(posedge clk)
    if (!rst) assert (!(e_valid && e_cs.m));
`endif
  always_comb begin
    stalls = '0;
    flushes = '0;
    if (rst) flushes = '1;
    else if (e_redirect) flushes = st(D) | st(E);
    else if (md_hold) begin
      stalls = st(F) | st(D) | st(E);
      flushes = st(M);
    end else if (load_use) begin
      stalls = st(F) | st(D);
      flushes = st(E);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;
`ifdef HAZARD_CTRL_RV32M_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, d_valid, d_use_rs1, d_use_rs2, e_valid, e_redirect;
  reg_ind_t d_rs1, d_rs2, e_rd;
  control_signals_t e_cs;
  logic [2:0] e_func3;
  logic [4:0] stalls, flushes;
  logic md_start, md_busy;
  int total = 0, passed = 0, fails = 0;
  int ph = -1;
  int lat = 0;
  int busy_seen, estall_seen;
  always #5 clk = ~clk;
  hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .e_valid(e_valid), .e_rd(e_rd),
    .e_cs(e_cs), .e_func3(e_func3), .e_redirect(e_redirect), .stalls(stalls),
    .flushes(flushes), .md_start(md_start), .md_busy(md_busy)
  );
  task automatic chk(string tag, logic [4:0] obs, logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic nop();
    d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0;
    e_valid = 0; e_rd = 0; e_cs = '0; e_func3 = 0; e_redirect = 0;
  endtask
  task automatic cycle(string tag);
    logic [4:0] es, ef;
    logic lu, go, ebusy;
    int lat_n;
    lu = e_valid && e_cs.l && e_rd != 0 && d_valid &&
         ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));
    go = MD_EN && !rst && ph < 0 && e_valid && e_cs.m && !e_redirect;
    ebusy = !rst && ph >= 1 && ph <= lat - 2;
    lat_n = e_func3[2] ? DIV_LAT : MUL_LAT;
    es = 5'b00000;
    ef = 5'b00000;
    if (rst) ef = 5'b11111;
    else if (e_redirect) ef = 5'b00110;
    else if (go || ebusy) begin es = 5'b00111; ef = 5'b01000; end
    else if (lu) begin es = 5'b00011; ef = 5'b00100; end
    #1;
    chk({tag, "_stalls"}, stalls, es);
    chk({tag, "_flushes"}, flushes, ef);
    chk({tag, "_md_start"}, {4'b0, md_start}, {4'b0, go});
    chk({tag, "_md_busy"}, {4'b0, md_busy}, {4'b0, ebusy});
    busy_seen += int'(md_busy);
    estall_seen += int'(stalls[2]);
    @(posedge clk);
    if (rst) ph = -1;
    else if (go) begin lat = lat_n; ph = 1; end
    else if (ph >= 0) ph = (ph >= lat - 1) ? -1 : ph + 1;
    #1;
  endtask
  initial begin
    nop();
    rst = 1;
    repeat (2) cycle("reset");
    rst = 0;
    cycle("post_reset");
    e_valid = 1; e_cs.l = 1; e_rd = 5; d_valid = 1; d_use_rs1 = 1; d_rs1 = 5;
    cycle("lu_rs1");
    e_rd = 0; d_rs1 = 0;
    cycle("lu_x0");
    e_rd = 7; d_use_rs1 = 0; d_use_rs2 = 1; d_rs2 = 7;
    cycle("lu_rs2");
    d_use_rs2 = 0;
    cycle("lu_unused");
    d_use_rs2 = 1; e_redirect = 1;
    cycle("redirect_lu");
    nop();
    cycle("idle");
    if (MD_EN) begin
      e_valid = 1; e_cs.m = 1; e_func3 = 3'b000;
      cycle("mul_start");
      cycle("mul_done");
      nop();
      cycle("mul_after");
      e_valid = 1; e_cs.m = 1; e_func3 = 3'b100;
      busy_seen = 0; estall_seen = 0;
      repeat (DIV_LAT) cycle("div");
      chk("div_busy_cycles", 5'(busy_seen), 5'(DIV_LAT - 2));
      chk("div_stall_cycles", 5'(estall_seen), 5'(DIV_LAT - 1));
      repeat (DIV_LAT) cycle("div_b2b");
      nop();
      cycle("div_gap");
      e_valid = 1; e_cs.m = 1; e_func3 = 3'b101;
      repeat (11) cycle("abort_run");
      rst = 1;
      cycle("abort_rst");
      rst = 0;
      nop();
      repeat (3) cycle("abort_after");
    end
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(63) == 0);
      d_valid = 1'($urandom);
      d_rs1 = 5'($urandom_range(3));
      d_rs2 = 5'($urandom_range(3));
      d_use_rs1 = 1'($urandom);
      d_use_rs2 = 1'($urandom);
      e_valid = 1'($urandom);
      e_rd = 5'($urandom_range(3));
      e_cs.l = 1'($urandom);
      e_cs.w = 1'($urandom);
      e_cs.m = MD_EN && ($urandom_range(7) == 0);
      e_func3 = 3'($urandom);
      e_redirect = !e_cs.m && ($urandom_range(7) == 0);
      cycle("rand");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
